// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: segment patterns, digit indices and decode helpers for seg_scan_decoder
package seg_scan_pkg;
  localparam int ONES = 0;
  localparam int TENS = 1;
  localparam int HUNDREDS = 2;
  localparam int THOUSANDS = 3;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  // Index n holds the {g,f,e,d,c,b,a} pattern of hex digit n.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] value;
  } dec_t;
  function automatic dec_t seg_decode(input logic [6:0] p);
    dec_t d;
    d = '{hit: p == SEG_BLANK, blank: p == SEG_BLANK, value: 4'h0};
    for (int i = 0; i < 16; i++)
      if (p == SEG_PAT[i]) d = '{hit: 1'b1, blank: 1'b0, value: 4'(i)};
    return d;
  endfunction
  function automatic logic one_hot(input logic [3:0] v);
    return v != 4'h0 && (v & (v - 4'h1)) == 4'h0;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: seven-segment pattern to {hit, blank, value}
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       hit_o,
  output logic       blank_o,
  output logic [3:0] value_o
);
  assign {hit_o, blank_o, value_o} = seg_decode(pat_i);
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 4-digit display scan and commits stable digits
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CNT = 2,
  parameter int SETTLE = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic        ck,
  input  logic        rst,
  input  logic [3:0]  s,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        upd,
  output logic        err_sel,
  output logic        err_pat,
  output logic        stale
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  logic [3:0] s_m_q, s_q, prev_s_q;
  logic [7:0] seg_m_q, seg_q;
  logic [SW-1:0] set_q, set_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic sampled_q, sampled_d;
  logic chg, sample_pt, take, wd_sat, hit, blank;
  logic [3:0] value;
  logic [15:0] digits_d;
  logic [3:0] dp_d, dv_d;
  seg7_decode u_dec (.pat_i(seg_q[6:0]), .hit_o(hit), .blank_o(blank), .value_o(value));
  always_comb begin
    chg = s_q != prev_s_q;
    sample_pt = !chg && !sampled_q && set_q == SW'(SETTLE - 1);
    take = sample_pt && one_hot(s_q);
    set_d = chg ? '0 : (set_q == SW'(SETTLE) ? set_q : set_q + SW'(1));
    sampled_d = !chg && (sampled_q || sample_pt);
    wd_d = chg ? '0 : (&wd_q ? wd_q : wd_q + TIMEOUT_W'(1));
    wd_sat = &wd_d && !(&wd_q);
  end
  // sampled_q resets high so nothing is sampled until a select change is seen after reset
  always_ff @(posedge ck) begin
    if (rst) begin
      s_m_q <= '0;
      s_q <= '0;
      prev_s_q <= '0;
      seg_m_q <= '0;
      seg_q <= '0;
      set_q <= '0;
      sampled_q <= 1'b1;
      wd_q <= '0;
      digits <= '0;
      dp <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      upd <= 1'b0;
      err_sel <= 1'b0;
      err_pat <= 1'b0;
    end else begin
      s_m_q <= s;
      s_q <= s_m_q;
      prev_s_q <= s_q;
      seg_m_q <= seg;
      seg_q <= seg_m_q;
      set_q <= set_d;
      sampled_q <= sampled_d;
      wd_q <= wd_d;
      digits <= digits_d;
      dp <= dp_d;
      digit_valid <= wd_sat ? '0 : dv_d;
      frame_valid <= !wd_sat && &dv_d;
      upd <= wd_sat || {digits_d, dp_d, dv_d} != {digits, dp, digit_valid};
      err_sel <= sample_pt && !one_hot(s_q);
      err_pat <= take && !hit;
    end
  end
  assign stale = &wd_q;
  for (genvar i = ONES; i <= THOUSANDS; i++) begin : g_dig
    logic [3:0] cv_q;
    logic cdp_q, cbl_q, hit_i, commit;
    logic [CW-1:0] cnt_q;
    assign hit_i = take && s_q[i];
    assign commit = cnt_q == CW'(STABLE_CNT);
    always_ff @(posedge ck) begin
      if (rst) begin
        cv_q <= '0;
        cdp_q <= 1'b0;
        cbl_q <= 1'b0;
        cnt_q <= '0;
      end else if (wd_sat || (hit_i && !hit)) begin
        cnt_q <= '0;
      end else if (hit_i) begin
        cv_q <= value;
        cdp_q <= seg_q[7];
        cbl_q <= blank;
        cnt_q <= {cv_q, cdp_q, cbl_q} != {value, seg_q[7], blank} ? CW'(1) :
                 commit ? cnt_q : cnt_q + CW'(1);
      end
    end
    // A committed digit keeps following its candidate, which only changes when the count restarts.
    assign digits_d[4*i +: 4] = commit ? cv_q : digits[4*i +: 4];
    assign dp_d[i] = commit ? cdp_q : dp[i];
    assign dv_d[i] = commit ? !cbl_q : digit_valid[i];
  end
endmodule
